decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
- Sequencing controller for the decode stage.
- Holds the IF/ID instruction register and drives its instruction into the combinational decoder.
- Uses the decoded opcode and register fields to detect load-use hazards against the instruction in EX, and inserts one bubble when needed.
- Issues instructions to EX with a valid/ready handshake, and handles pipeline flush from branch/jump resolution.

Parameters:
- OP_LOAD, 5'b00000, opcode field inst[6:2] of loads
- STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  controller accepts an instruction this cycle
- in_inst  input  32  fetched instruction
- in_pc  input  32  PC of in_inst
- out_valid  output  1  held instruction is issuable to EX this cycle
- out_ready  input  1  EX accepts the issue (or accepts a bubble)
- out_inst  output  32  held IF/ID instruction; also drives the decoder input
- out_pc  output  32  PC of out_inst
- id_opcode  input  5  decoder opcode for out_inst
- id_rs1  input  5  decoder rs1 for out_inst
- id_rs2  input  5  decoder rs2 for out_inst
- id_rd  input  5  decoder rd for out_inst
- flush  input  1  kill the held instruction and the EX load tracking
- stall  output  1  hazard bubble being inserted this cycle
- stall_cnt  output  STALL_CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (async, asserted): id_valid=0, out_inst=32'h00000013 (NOP), out_pc=0, ex_load=0, ex_rd=0, stall_cnt=0, state=EMPTY.
- Source-use by id_opcode:
  - none: 01101, 00101, 11011.
  - rs1 only: 00100, 00000, 11001.
  - rs1 and rs2: 01100, 01000, 11000.
  - Any other opcode: none.
- Hazard: hazard = id_valid & ex_load & ex_rd!=0 & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd)).
- Combinational handshake outputs:
  - out_valid = id_valid & !hazard & !flush.
  - stall = id_valid & hazard & !flush.
  - fire = out_valid & out_ready.
  - in_ready = !flush & (!id_valid | fire).
- Register updates:
  - accept = in_valid & in_ready: out_inst/out_pc load in_inst/in_pc; id_valid=1.
  - fire without accept: id_valid=0; out_inst keeps its value.
- EX tracking, updated only when out_ready=1:
  - On fire: ex_load<=(id_opcode==OP_LOAD); ex_rd<=id_rd.
  - Otherwise (bubble or empty): ex_load<=0.
  - out_ready=0: ex_load and ex_rd hold.
- Latency and throughput:
  - An instruction accepted in cycle N is issuable from N+1.
  - Throughput is 1/cycle with no hazards.
  - A load-use pair costs exactly one bubble cycle, provided out_ready=1.
- FSM:
  - EMPTY: id_valid=0.
  - READY: held and no hazard.
  - STALL: held and hazard.
  - Transitions: EMPTY->READY on accept. READY->EMPTY on fire without accept. READY->STALL when the newly accepted instruction hazards against the load just issued. STALL->READY after a bubble is taken with out_ready=1. Any state->EMPTY on flush.
- flush (priority over everything):
  - Next cycle: id_valid=0, ex_load=0, state=EMPTY.
  - in_inst is not accepted in the flush cycle.
  - out_inst/out_pc hold their values.
- stall_cnt increments on each cycle with stall=1 & out_ready=1, and saturates at all-ones.
- Reset mid-stall returns immediately to reset values; no issue occurs after release until a new accept.
- Simultaneous fire and accept in the same cycle is legal; it replaces the held instruction with no gap.

Test Plan:
- Reset, then hold in_valid=0 -> out_valid=0, in_ready=1, out_inst=0x00000013, stall_cnt=0.
- Stream 0x00012283 (lw x5,0(x2)) then 0x00128333 (add x6,x5,x1), out_ready=1 -> lw issues, next cycle stall=1 and out_valid=0, then add issues one cycle later; stall_cnt=1.
- Stream 0x00012003 (lw x0) then 0x00128333 -> no bubble, back-to-back issue; stall_cnt=0.
- Stream 0x00012283 then 0x000012B7 (lui x5,1) -> no bubble, since lui uses no rs.
- Load-use pair with out_ready=0 for 3 cycles during STALL -> ex_load holds, stall_cnt unchanged; bubble and issue occur only after out_ready=1; in_ready=0 throughout.
- Assert flush during STALL -> next cycle out_valid=0 and state EMPTY; a following 0x00128333 issues with no bubble.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// Decode-stage sequencing controller: IF/ID register, load-use bubble insertion,
// valid/ready issue to EX, and flush handling.
module decode_issue_ctrl #(
    parameter logic [4:0] OP_LOAD     = 5'b00000,
    parameter int         STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [31:0]            in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_inst,
    output logic [31:0]            out_pc,
    input  logic [4:0]             id_opcode,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             id_rd,
    input  logic                   flush,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_READY,
        S_STALL
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Returns {uses_rs2, uses_rs1} for a decoded opcode.
    function automatic logic [1:0] src_use(input logic [4:0] op);
        case (op)
            5'b00100, 5'b00000, 5'b11001: src_use = 2'b01;
            5'b01100, 5'b01000, 5'b11000: src_use = 2'b11;
            default:                      src_use = 2'b00;
        endcase
    endfunction

    function automatic logic load_use(
        input logic       valid,
        input logic [4:0] op,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       eload,
        input logic [4:0] erd
    );
        logic [1:0] u;
        u = src_use(op);
        load_use = valid & eload & (erd != 5'd0) &
                   ((u[0] & (rs1 == erd)) | (u[1] & (rs2 == erd)));
    endfunction

    state_e                 state_q,     state_d;
    logic [31:0]            inst_q,      inst_d;
    logic [31:0]            pc_q,        pc_d;
    logic                   ex_load_q,   ex_load_d;
    logic [4:0]             ex_rd_q,     ex_rd_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic id_valid, id_valid_d, hazard, fire, accept;

    assign id_valid  = (state_q != S_EMPTY);
    assign out_inst  = inst_q;
    assign out_pc    = pc_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        state_d     = state_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        ex_load_d   = ex_load_q;
        ex_rd_d     = ex_rd_q;
        stall_cnt_d = stall_cnt_q;
        id_valid_d  = id_valid;

        hazard    = load_use(id_valid, id_opcode, id_rs1, id_rs2, ex_load_q, ex_rd_q);
        out_valid = id_valid & ~hazard & ~flush;
        stall     = id_valid & hazard & ~flush;
        fire      = out_valid & out_ready;
        in_ready  = ~flush & (~id_valid | fire);
        accept    = in_valid & in_ready;

        if (accept) begin
            inst_d     = in_inst;
            pc_d       = in_pc;
            id_valid_d = 1'b1;
        end else if (fire) begin
            id_valid_d = 1'b0;
        end

        if (flush) begin
            id_valid_d = 1'b0;
            ex_load_d  = 1'b0;
        end else if (out_ready) begin
            if (fire) begin
                ex_load_d = (id_opcode == OP_LOAD);
                ex_rd_d   = id_rd;
            end else begin
                ex_load_d = 1'b0;
            end
        end

        if (stall && out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};

        // Next state classifies the instruction held next cycle against the next EX tracking.
        if (!id_valid_d)
            state_d = S_EMPTY;
        else if (accept ? load_use(1'b1, in_inst[6:2], in_inst[19:15], in_inst[24:20],
                                   ex_load_d, ex_rd_d)
                        : load_use(1'b1, id_opcode, id_rs1, id_rs2, ex_load_d, ex_rd_d))
            state_d = S_STALL;
        else
            state_d = S_READY;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            inst_q      <= NOP_INST;
            pc_q        <= 32'd0;
            ex_load_q   <= 1'b0;
            ex_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            ex_load_q   <= ex_load_d;
            ex_rd_q     <= ex_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl; a behavioural decoder
// slices the held instruction into the id_* fields.
module tb_decode_issue_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] LW_X5  = 32'h0001_2283;
    localparam logic [31:0] LW_X0  = 32'h0001_2003;
    localparam logic [31:0] ADD_X6 = 32'h0012_8333;
    localparam logic [31:0] LUI_X5 = 32'h0000_12B7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  id_opcode, id_rs1, id_rs2, id_rd;
    logic        flush;
    logic        stall;
    logic [15:0] stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign id_opcode = out_inst[6:2];
    assign id_rd     = out_inst[11:7];
    assign id_rs1    = out_inst[19:15];
    assign id_rs2    = out_inst[24:20];

    decode_issue_ctrl #(.OP_LOAD(5'b00000), .STALL_CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .id_opcode (id_opcode),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .flush     (flush),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = inst ^ 32'h1000_0000;
        out_ready = ordy;
        flush     = fl;
        settle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1; flush = 1'b0;
        #1;
        do_reset();

        // Reset state with in_valid low
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_inst", out_inst, NOP);
        check("rst_out_pc", out_pc, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        tick();

        // lw x5 then add x6,x5,x1: one bubble
        drive(1'b1, LW_X5, 1'b1, 1'b0);
        check("lu_accept_lw", in_ready, 1);
        check("lu_empty_nvalid", out_valid, 0);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b0);
        check("lu_lw_valid", out_valid, 1);
        check("lu_lw_inst", out_inst, LW_X5);
        check("lu_lw_pc", out_pc, LW_X5 ^ 32'h1000_0000);
        check("lu_lw_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("lu_bubble_stall", stall, 1);
        check("lu_bubble_nvalid", out_valid, 0);
        check("lu_bubble_in_ready", in_ready, 0);
        check("lu_bubble_cnt0", stall_cnt, 0);
        tick();
        check("lu_add_valid", out_valid, 1);
        check("lu_add_stall", stall, 0);
        check("lu_add_inst", out_inst, ADD_X6);
        check("lu_cnt1", stall_cnt, 1);
        tick();
        check("lu_drained", out_valid, 0);
        check("lu_drained_ready", in_ready, 1);

        // lw x0 then add: no bubble
        do_reset();
        drive(1'b1, LW_X0, 1'b1, 1'b0);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b0);
        check("x0_lw_valid", out_valid, 1);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("x0_add_valid", out_valid, 1);
        check("x0_add_stall", stall, 0);
        check("x0_add_inst", out_inst, ADD_X6);
        tick();
        check("x0_cnt", stall_cnt, 0);

        // lw x5 then lui x5: no source use, no bubble
        do_reset();
        drive(1'b1, LW_X5, 1'b1, 1'b0);
        tick();
        drive(1'b1, LUI_X5, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("lui_valid", out_valid, 1);
        check("lui_stall", stall, 0);
        check("lui_inst", out_inst, LUI_X5);
        tick();
        check("lui_cnt", stall_cnt, 0);

        // Load-use with out_ready low for three cycles during the stall
        do_reset();
        drive(1'b1, LW_X5, 1'b1, 1'b0);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, LUI_X5, 1'b0, 1'b0);
            check("bp_stall", stall, 1);
            check("bp_nvalid", out_valid, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_cnt", stall_cnt, 0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_release_stall", stall, 1);
        check("bp_release_ready", in_ready, 0);
        tick();
        check("bp_add_valid", out_valid, 1);
        check("bp_add_inst", out_inst, ADD_X6);
        check("bp_cnt1", stall_cnt, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Flush during stall
        do_reset();
        drive(1'b1, LW_X5, 1'b1, 1'b0);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b0);
        tick();
        drive(1'b1, LUI_X5, 1'b1, 1'b1);
        check("fl_nvalid", out_valid, 0);
        check("fl_nstall", stall, 0);
        check("fl_in_ready", in_ready, 0);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b0);
        check("fl_empty", out_valid, 0);
        check("fl_hold_inst", out_inst, ADD_X6);
        check("fl_cnt", stall_cnt, 0);
        check("fl_accept", in_ready, 1);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("fl_add_valid", out_valid, 1);
        check("fl_add_stall", stall, 0);
        tick();

        // Reset in the middle of a stall
        drive(1'b1, LW_X5, 1'b1, 1'b0);
        tick();
        drive(1'b1, ADD_X6, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        check("mr_pre_stall", stall, 1);
        rst = 1'b1;
        settle();
        check("mr_inst", out_inst, NOP);
        check("mr_nstall", stall, 0);
        check("mr_nvalid", out_valid, 0);
        tick();
        rst = 1'b0;
        settle();
        tick();
        check("mr_no_issue", out_valid, 0);
        check("mr_cnt", stall_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
